pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/rv_fetch_pkg.sv | 23 ++
 rtl/pc_fetch_if.sv | 37 +++
 rtl/fetch_queue.sv | 84 ++++++++
 rtl/pc_fetch.sv | 115 +++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package : rv_fetch_pkg
// Purpose : Shared types and constants for the instruction fetch slice.
//           Holds the fetch FSM state encoding, the instruction size in bytes,
//           the instruction queue depth and the default reset PC.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package rv_fetch_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam int          QDEPTH           = 2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

endpackage : rv_fetch_pkg
`default_nettype wire

// File: rtl/pc_fetch_if.sv
`default_nettype none
// ============================================================================
// Interface : pc_fetch_if
// Purpose   : Bundles the instruction-memory request/response signals and the
//             downstream valid/ready instruction stream of pc_fetch.
// Signals   : imem_req/imem_addr/imem_rdata - fetch request and 1-cycle response
//             out_valid/out_ready/out_instr/out_pc - queue head handshake
//             PCSrc/ImmOp - branch decision and offset for the accepted head
//             misalign_err - sticky misaligned-redirect flag
// Modports  : master = fetch unit side, slave = memory/downstream side
// Rev       : 1.0  initial release
// ============================================================================
interface pc_fetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [DATA_WIDTH-1:0] out_pc;
  logic                  PCSrc;
  logic [DATA_WIDTH-1:0] ImmOp;
  logic                  misalign_err;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, misalign_err,
    input  imem_rdata, out_ready, PCSrc, ImmOp
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, misalign_err,
    output imem_rdata, out_ready, PCSrc, ImmOp
  );
endinterface : pc_fetch_if
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Purpose : Two-entry FIFO of {pc, instr} pairs between the fetch unit and the
//           downstream stage. Push and pop may happen together at any
//           occupancy, including full. clr empties the queue and wins over a
//           same-cycle push.
// Ports   : clk, rst (async, active-high)
//           clr                      - drop all entries
//           push, push_pc, push_instr - write a new tail entry
//           pop                      - retire the head entry
//           full, empty              - occupancy status
//           head_pc, head_instr      - current head entry
// Rev     : 1.0  initial release
// ============================================================================
module fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  clr,
  input  wire logic                  push,
  input  wire logic [DATA_WIDTH-1:0] push_pc,
  input  wire logic [DATA_WIDTH-1:0] push_instr,
  input  wire logic                  pop,
  output logic                       full,
  output logic                       empty,
  output logic [DATA_WIDTH-1:0]      head_pc,
  output logic [DATA_WIDTH-1:0]      head_instr
);

  localparam logic [1:0] c_depth = 2'(QDEPTH);

  logic [DATA_WIDTH-1:0] r_pc    [QDEPTH];
  logic [DATA_WIDTH-1:0] r_instr [QDEPTH];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  logic w_do_pop;
  logic w_do_push;

  // A push into a full queue is legal only because the head frees up in the
  // same cycle.
  assign w_do_pop  = pop && (r_count != 2'd0);
  assign w_do_push = push && ((r_count != c_depth) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (clr) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_do_push) r_wptr <= ~r_wptr;
      if (w_do_pop)  r_rptr <= ~r_rptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !clr) begin
      r_pc[r_wptr]    <= push_pc;
      r_instr[r_wptr] <= push_instr;
    end
  end

  assign full       = (r_count == c_depth);
  assign empty      = (r_count == 2'd0);
  assign head_pc    = r_pc[r_rptr];
  assign head_instr = r_instr[r_rptr];

endmodule : fetch_queue
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch
// Purpose : Sequential instruction fetch unit. Issues one fetch per cycle to a
//           fixed 1-cycle-latency instruction memory, buffers responses in a
//           2-entry queue and hands them downstream over valid/ready. A taken
//           branch on the accepted instruction redirects fetch to
//           out_pc + ImmOp, flushing the queue and any in-flight response.
// Ports   : clk, rst (async, active-high)
//           bus (pc_fetch_if.master): imem_req/imem_addr/imem_rdata,
//           out_valid/out_ready/out_instr/out_pc, PCSrc/ImmOp, misalign_err
// Rev     : 1.0  initial release
// ============================================================================
module pc_fetch
  import rv_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  wire logic   clk,
  input  wire logic   rst,
  pc_fetch_if.master  bus
);

  localparam logic [DATA_WIDTH-1:0] c_pc_step = DATA_WIDTH'(INSTR_BYTES);

  fetch_state_t          r_state;
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_inflight_pc;
  logic                  r_misalign;

  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_head_pc;
  logic [DATA_WIDTH-1:0] w_head_instr;
  logic                  w_valid;
  logic                  w_transfer;
  logic                  w_redirect;
  logic [DATA_WIDTH-1:0] w_target;
  logic [2:0]            w_used;
  logic [2:0]            w_limit;
  logic                  w_req;
  logic                  w_push;

  assign w_valid    = !w_empty;
  assign w_transfer = w_valid && bus.out_ready;
  assign w_redirect = w_transfer && bus.PCSrc;
  assign w_target   = w_head_pc + bus.ImmOp;

  // Credits: slots held by queued entries plus the outstanding response. A
  // head leaving this cycle frees its slot in time for the new response,
  // which keeps the stream at one instruction per cycle.
  assign w_used  = (w_full ? 3'd2 : (w_empty ? 3'd0 : 3'd1)) + {2'b00, r_inflight};
  assign w_limit = 3'(QDEPTH) + {2'b00, w_transfer};
  assign w_req   = (r_state == RUN) && !w_redirect && (w_used < w_limit);

  // A response landing in a redirect cycle belongs to the discarded path.
  assign w_push = r_inflight && !w_redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= BOOT;
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
      r_misalign    <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + c_pc_step;
      end

      case (r_state)
        BOOT:     r_state <= RUN;
        RUN:      if (w_redirect) r_state <= REDIRECT;
        REDIRECT: r_state <= RUN;
        default:  r_state <= BOOT;
      endcase

      // w_req is low whenever w_redirect is high, so this never competes
      // with the sequential increment above.
      if (w_redirect) begin
        r_fetch_pc <= {w_target[DATA_WIDTH-1:2], 2'b00};
        if (w_target[1:0] != 2'b00) r_misalign <= 1'b1;
      end
    end
  end

  fetch_queue #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .clr        (w_redirect),
    .push       (w_push),
    .push_pc    (r_inflight_pc),
    .push_instr (bus.imem_rdata),
    .pop        (w_transfer),
    .full       (w_full),
    .empty      (w_empty),
    .head_pc    (w_head_pc),
    .head_instr (w_head_instr)
  );

  assign bus.imem_req     = w_req;
  assign bus.imem_addr    = r_fetch_pc;
  assign bus.out_valid    = w_valid;
  assign bus.out_pc       = w_head_pc;
  assign bus.out_instr    = w_head_instr;
  assign bus.misalign_err = r_misalign;

endmodule : pc_fetch
`default_nettype wire
